// File: rtl/regbank_access_pkg.sv
// rtl/regbank_access_pkg.sv - shared types and constants for the register bank access controller
// Purpose: state encoding, op codes and default widths used by regbank_access_ctrl and rr_arbiter.
// Ports: none (package).
package regbank_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SWAP_RD,
    ST_SWAP_W1,
    ST_SWAP_W2
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_SWAP  = 1'b1;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter with one-hot grant
// Purpose: picks one requester per cycle; the pointer moves past the winner only when the
//          grant is actually consumed (i_advance). With REGBANK_ACCESS_CTRL_FIXED_PRIO_EN
//          defined, the lowest requesting index always wins and no pointer exists.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_req         per-requester request
//   i_advance     the current grant was taken this cycle
//   o_grant       one-hot or zero grant (combinational)
module rr_arbiter
  import regbank_access_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

`ifdef REGBANK_ACCESS_CTRL_FIXED_PRIO_EN

  always_comb begin
    o_grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_grant = N'(1) << i;
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, i_clk, i_rst, i_advance};

`else

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [PW:0]   w_cand;
  logic          w_found;

  // Scan N slots starting at the pointer; the extra bit in w_cand lets the wrap be done
  // with a compare/subtract so non-power-of-two N never indexes past N-1.
  always_comb begin
    o_grant = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_cand >= (PW+1)'(N)) w_cand = w_cand - (PW+1)'(N);
      if (!w_found && i_req[w_cand[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PW-1:0];
      end
    end
    if (w_found) o_grant[w_win] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    end
  end

`endif

endmodule

// File: rtl/regbank_access_ctrl.sv
// rtl/regbank_access_ctrl.sv - write-port arbiter and swap sequencer for the 32x32 register bank
// Purpose: shares the bank write port among NUM_REQ requesters, runs SWAP as read/write/write
//          over that single port, and stalls the datapath while a swap owns the read ports.
//          Optional macro REGBANK_ACCESS_CTRL_FIXED_PRIO_EN selects fixed-priority arbitration.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid/o_req_ready      per-requester handshake (ready one-hot or zero)
//   i_req_op/_a/_b/_wd           packed per-requester command fields
//   i_ext_ra1/2, o_ext_stall     datapath read addresses and hold request
//   o_rb_regwrite/_wa/_wd        bank write port
//   o_rb_ra1/2, i_rb_rd1/2       bank read ports (read data combinational)
//   o_busy                       controller not idle
module regbank_access_ctrl
  import regbank_access_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ-1:0]    i_req_op,
  input  logic [NUM_REQ*AW-1:0] i_req_a,
  input  logic [NUM_REQ*AW-1:0] i_req_b,
  input  logic [NUM_REQ*DW-1:0] i_req_wd,
  input  logic [AW-1:0]         i_ext_ra1,
  input  logic [AW-1:0]         i_ext_ra2,
  output logic                  o_ext_stall,
  output logic                  o_rb_regwrite,
  output logic [AW-1:0]         o_rb_wa,
  output logic [DW-1:0]         o_rb_wd,
  output logic [AW-1:0]         o_rb_ra1,
  output logic [AW-1:0]         o_rb_ra2,
  input  logic [DW-1:0]         i_rb_rd1,
  input  logic [DW-1:0]         i_rb_rd2,
  output logic                  o_busy
);

  state_t        r_state;
  logic          r_regwrite;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wd;
  logic          r_stall;
  logic          r_busy;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_b;
  logic [DW-1:0] r_ta;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_window;
  logic               w_hs;
  logic               w_sel_op;
  logic [AW-1:0]      w_sel_a;
  logic [AW-1:0]      w_sel_b;
  logic [DW-1:0]      w_sel_wd;

  assign w_window    = (r_state == ST_IDLE) || (r_state == ST_WRITE);
  // Gated by i_rst so no handshake is offered while the controller is held in reset.
  assign o_req_ready = (w_window && !i_rst) ? w_grant : '0;
  assign w_hs        = |(i_req_valid & o_req_ready);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req_valid),
    .i_advance (w_hs),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_sel_op = OP_WRITE;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_wd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = i_req_op[i];
        w_sel_a  = i_req_a[i*AW +: AW];
        w_sel_b  = i_req_b[i*AW +: AW];
        w_sel_wd = i_req_wd[i*DW +: DW];
      end
    end
  end

  assign o_rb_ra1      = (r_state == ST_SWAP_RD) ? r_a : i_ext_ra1;
  assign o_rb_ra2      = (r_state == ST_SWAP_RD) ? r_b : i_ext_ra2;
  assign o_ext_stall   = r_stall;
  assign o_rb_regwrite = r_regwrite;
  assign o_rb_wa       = r_wa;
  assign o_rb_wd       = r_wd;
  assign o_busy        = r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_regwrite <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_stall    <= 1'b0;
      r_busy     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_ta       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WRITE: begin
          // A write shown on the port this cycle commits on this edge regardless of
          // what is accepted, so a following swap read sees it.
          if (w_hs && (w_sel_op == OP_WRITE)) begin
            r_state    <= ST_WRITE;
            r_regwrite <= 1'b1;
            r_wa       <= w_sel_a;
            r_wd       <= w_sel_wd;
            r_stall    <= 1'b0;
            r_busy     <= 1'b1;
          end else if (w_hs) begin
            r_state    <= ST_SWAP_RD;
            r_regwrite <= 1'b0;
            r_a        <= w_sel_a;
            r_b        <= w_sel_b;
            r_stall    <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_state    <= ST_IDLE;
            r_regwrite <= 1'b0;
            r_stall    <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ST_SWAP_RD: begin
          // The old value of b goes straight onto the write port; only a's value must be
          // held for the second write.
          r_ta <= i_rb_rd1;
          if (r_a == r_b) begin
            r_state <= ST_IDLE;
            r_stall <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= ST_SWAP_W1;
            r_regwrite <= 1'b1;
            r_wa       <= r_a;
            r_wd       <= i_rb_rd2;
          end
        end
        ST_SWAP_W1: begin
          r_state    <= ST_SWAP_W2;
          r_regwrite <= 1'b1;
          r_wa       <= r_b;
          r_wd       <= r_ta;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_regwrite <= 1'b0;
          r_stall    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// tb/tb_regbank_access_ctrl.sv - randomized self-checking bench for regbank_access_ctrl
module tb_regbank_access_ctrl;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_op;
  logic [N*AW-1:0] req_a;
  logic [N*AW-1:0] req_b;
  logic [N*DW-1:0] req_wd;
  logic [AW-1:0]   ext_ra1, ext_ra2, rb_ra1, rb_ra2, rb_wa;
  logic            ext_stall, rb_regwrite, busy;
  logic [DW-1:0]   rb_wd, rb_rd1, rb_rd2;

  always #5 clk = ~clk;

  regbank_access_ctrl #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_wd(req_wd),
    .i_ext_ra1(ext_ra1), .i_ext_ra2(ext_ra2), .o_ext_stall(ext_stall),
    .o_rb_regwrite(rb_regwrite), .o_rb_wa(rb_wa), .o_rb_wd(rb_wd),
    .o_rb_ra1(rb_ra1), .o_rb_ra2(rb_ra2), .i_rb_rd1(rb_rd1), .i_rb_rd2(rb_rd2),
    .o_busy(busy)
  );

  // Environment: the 32x32 bank itself.
  logic [DW-1:0] bank [32];
  logic          tb_load;
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) bank[i] <= (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end else if (rb_regwrite) begin
      bank[rb_wa] <= rb_wd;
    end
  end
  assign rb_rd1 = bank[rb_ra1];
  assign rb_rd2 = bank[rb_ra2];

  // Reference model: bank contents in command order, a schedule of expected port writes,
  // the stall window left by a swap, and the round-robin pointer.
  logic [DW-1:0] ref_bank [32];
  bit            sch_we [4];
  logic [AW-1:0] sch_wa [4];
  logic [DW-1:0] sch_wd [4];
  int            stall_left;
  bit            rd_flag;
  logic [AW-1:0] m_a, m_b;
  int            m_ptr;

  // Per-cycle stimulus.
  logic [N-1:0]  d_valid;
  bit            d_op [N];
  logic [AW-1:0] d_a [N];
  logic [AW-1:0] d_b [N];
  logic [DW-1:0] d_wd [N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sch_we[i] = 0; sch_wa[i] = '0; sch_wd[i] = '0;
    end
    stall_left = 0;
    rd_flag    = 0;
    m_ptr      = 0;
  endtask

  task automatic set_req(input int i, input bit op, input int a, input int b, input logic [31:0] wd);
    d_valid[i] = 1'b1;
    d_op[i]    = op;
    d_a[i]     = AW'(a);
    d_b[i]     = AW'(b);
    d_wd[i]    = wd;
  endtask

  task automatic do_cycle();
    bit            cur_stall, cur_rd;
    int            g;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] tmp;
    @(negedge clk);
    cur_stall = (stall_left > 0);
    cur_rd    = cur_stall && rd_flag;
    check("rb_regwrite", 32'(rb_regwrite), 32'(sch_we[0]));
    if (sch_we[0]) begin
      check("rb_wa", 32'(rb_wa), 32'(sch_wa[0]));
      check("rb_wd", rb_wd, sch_wd[0]);
    end
    check("ext_stall", 32'(ext_stall), 32'(cur_stall));
    check("busy", 32'(busy), 32'(cur_stall | sch_we[0]));
    for (int i = 0; i < 3; i++) begin
      sch_we[i] = sch_we[i+1]; sch_wa[i] = sch_wa[i+1]; sch_wd[i] = sch_wd[i+1];
    end
    sch_we[3] = 0;
    if (stall_left > 0) stall_left--;
    rd_flag = 0;

    req_valid = d_valid;
    for (int i = 0; i < N; i++) begin
      req_op[i]            = d_op[i];
      req_a[i*AW +: AW]    = d_a[i];
      req_b[i*AW +: AW]    = d_b[i];
      req_wd[i*DW +: DW]   = d_wd[i];
    end
    ext_ra1 = AW'($urandom_range(0, 31));
    ext_ra2 = AW'($urandom_range(0, 31));
    #1;

    g = -1;
    if (!cur_stall) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && d_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rb_ra1", 32'(rb_ra1), 32'(cur_rd ? m_a : ext_ra1));
    check("rb_ra2", 32'(rb_ra2), 32'(cur_rd ? m_b : ext_ra2));

    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (!d_op[g]) begin
        sch_we[0] = 1; sch_wa[0] = d_a[g]; sch_wd[0] = d_wd[g];
        ref_bank[d_a[g]] = d_wd[g];
      end else begin
        m_a = d_a[g];
        m_b = d_b[g];
        rd_flag = 1;
        if (m_a == m_b) begin
          stall_left = 1;
        end else begin
          stall_left = 3;
          sch_we[1] = 1; sch_wa[1] = m_a; sch_wd[1] = ref_bank[m_b];
          sch_we[2] = 1; sch_wa[2] = m_b; sch_wd[2] = ref_bank[m_a];
          tmp = ref_bank[m_a];
          ref_bank[m_a] = ref_bank[m_b];
          ref_bank[m_b] = tmp;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    d_valid = '0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic compare_bank();
    for (int i = 0; i < 32; i++) check($sformatf("bank_r%0d", i), bank[i], ref_bank[i]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    #1;
    check("rst_regwrite", 32'(rb_regwrite), 32'd0);
    check("rst_wa", 32'(rb_wa), 32'd0);
    check("rst_wd", rb_wd, 32'd0);
    check("rst_stall", 32'(ext_stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; tb_load = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_wd = '0;
    ext_ra1 = '0; ext_ra2 = '0;
    d_valid = '0;
    for (int i = 0; i < N; i++) begin
      d_op[i] = 0; d_a[i] = '0; d_b[i] = '0; d_wd[i] = '0;
    end
    for (int i = 0; i < 32; i++) ref_bank[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    tb_load = 1'b0;
    apply_reset();

    // Single write from requester 2.
    d_valid = '0;
    set_req(2, 0, 5, 0, 32'hDEAD_BEEF);
    do_cycle();
    idle_cycles(3);
    check("r5_written", bank[5], 32'hDEAD_BEEF);

    // Four requesters streaming writes: grants rotate 0,1,2,3,0 after reset.
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 0, 10 + i + 4 * c, 0, $urandom);
      do_cycle();
    end
    idle_cycles(2);

    // Swap r3/r7.
    d_valid = '0; set_req(0, 0, 3, 0, 32'h11); do_cycle();
    d_valid = '0; set_req(1, 0, 7, 0, 32'h22); do_cycle();
    idle_cycles(2);
    d_valid = '0; set_req(2, 1, 3, 7, 32'h0); do_cycle();
    idle_cycles(5);
    check("swap_r3", bank[3], 32'h22);
    check("swap_r7", bank[7], 32'h11);

    // Degenerate swap r4/r4.
    d_valid = '0; set_req(3, 1, 4, 4, 32'h0); do_cycle();
    idle_cycles(3);
    check("swap_same_r4", bank[4], ref_bank[4]);

    // Write r3 then swap 3,9 on the following cycle.
    d_valid = '0; set_req(0, 0, 3, 0, 32'h55); do_cycle();
    d_valid = '0; set_req(1, 1, 3, 9, 32'h0); do_cycle();
    idle_cycles(5);
    check("wr_swap_r9", bank[9], 32'h55);
    compare_bank();

    // Reset right after the first swap write commits.
    d_valid = '0; set_req(0, 0, 3, 0, 32'h11); do_cycle();
    d_valid = '0; set_req(1, 0, 7, 0, 32'h22); do_cycle();
    idle_cycles(2);
    d_valid = '0; set_req(2, 1, 3, 7, 32'h0); do_cycle();
    d_valid = '0;
    do_cycle();
    do_cycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_regwrite", 32'(rb_regwrite), 32'd0);
    check("midrst_stall", 32'(ext_stall), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ref_bank[3] = 32'h22;
    ref_bank[7] = 32'h22;
    check("midrst_r3", bank[3], 32'h22);
    check("midrst_r7", bank[7], 32'h22);
    d_valid = '0; set_req(1, 0, 7, 0, 32'h11); do_cycle();
    idle_cycles(2);
    check("post_rst_r7", bank[7], 32'h11);

    // Randomized traffic.
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 60; c++) begin
        for (int i = 0; i < N; i++) begin
          d_valid[i] = ($urandom_range(0, 3) != 0);
          d_op[i]    = ($urandom_range(0, 4) == 0);
          d_a[i]     = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
          d_b[i]     = AW'(($urandom_range(0, 3) == 0) ? d_a[i] : AW'($urandom_range(0, 7)));
          d_wd[i]    = $urandom;
        end
        do_cycle();
      end
      idle_cycles(5);
      compare_bank();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
